// File: rtl/zscale_ahb_arbiter.sv
// Two-master AHB-Lite arbiter: buffers one address phase per Zscale master (imem/dmem),
// replays the winner on a single slave port and steers the data phase back to its owner.
module zscale_ahb_arbiter #(
  parameter int unsigned XLen          = 32,
  parameter bit          DMEM_PRIORITY = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      io_imem_htrans,
  input  logic [XLen-1:0] io_imem_haddr,
  input  logic            io_imem_hwrite,
  input  logic [2:0]      io_imem_hsize,
  input  logic [2:0]      io_imem_hburst,
  input  logic [3:0]      io_imem_hprot,
  input  logic            io_imem_hmastlock,
  input  logic [XLen-1:0] io_imem_hwdata,
  output logic [XLen-1:0] io_imem_hrdata,
  output logic            io_imem_hready,
  output logic            io_imem_hresp,
  input  logic [1:0]      io_dmem_htrans,
  input  logic [XLen-1:0] io_dmem_haddr,
  input  logic            io_dmem_hwrite,
  input  logic [2:0]      io_dmem_hsize,
  input  logic [2:0]      io_dmem_hburst,
  input  logic [3:0]      io_dmem_hprot,
  input  logic            io_dmem_hmastlock,
  input  logic [XLen-1:0] io_dmem_hwdata,
  output logic [XLen-1:0] io_dmem_hrdata,
  output logic            io_dmem_hready,
  output logic            io_dmem_hresp,
  output logic [1:0]      io_slv_htrans,
  output logic [XLen-1:0] io_slv_haddr,
  output logic            io_slv_hwrite,
  output logic [2:0]      io_slv_hsize,
  output logic [2:0]      io_slv_hburst,
  output logic [3:0]      io_slv_hprot,
  output logic            io_slv_hmastlock,
  output logic [XLen-1:0] io_slv_hwdata,
  input  logic [XLen-1:0] io_slv_hrdata,
  input  logic            io_slv_hready,
  input  logic            io_slv_hresp
);

  typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_I = 2'd1, SEL_D = 2'd2} sel_e;

  typedef struct packed {
    logic [XLen-1:0] addr;
    logic            write;
    logic [2:0]      size;
    logic [3:0]      prot;
    logic            lock;
  } req_t;

  logic i_pend_q, i_pend_d, d_pend_q, d_pend_d;
  req_t i_req_q, i_req_d, d_req_q, d_req_d;
  sel_e owner_q, owner_d, hold_q, hold_d, rr_last_q, rr_last_d;
  sel_e arb, addr_sel;
  logic imem_rdy, dmem_rdy, i_cap, d_cap;

  logic unused_ok;
  assign unused_ok = ^{io_imem_hburst, io_dmem_hburst, io_imem_htrans[0], io_dmem_htrans[0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      i_pend_q  <= 1'b0;
      d_pend_q  <= 1'b0;
      i_req_q   <= '0;
      d_req_q   <= '0;
      owner_q   <= SEL_NONE;
      hold_q    <= SEL_NONE;
      rr_last_q <= SEL_I;
    end else begin
      i_pend_q  <= i_pend_d;
      d_pend_q  <= d_pend_d;
      i_req_q   <= i_req_d;
      d_req_q   <= d_req_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      rr_last_q <= rr_last_d;
    end
  end

  // A NONSEQ already shown during a slave wait state stays on the bus until accepted,
  // even if a higher-priority request is buffered meanwhile.
  always_comb begin
    arb = SEL_NONE;
    if (i_pend_q && d_pend_q)
      arb = (DMEM_PRIORITY || rr_last_q == SEL_I) ? SEL_D : SEL_I;
    else if (d_pend_q)
      arb = SEL_D;
    else if (i_pend_q)
      arb = SEL_I;
    addr_sel = (hold_q != SEL_NONE) ? hold_q : arb;
  end

  always_comb begin
    i_cap     = !i_pend_q && imem_rdy && io_imem_htrans[1];
    d_cap     = !d_pend_q && dmem_rdy && io_dmem_htrans[1];
    i_pend_d  = i_pend_q;
    d_pend_d  = d_pend_q;
    i_req_d   = i_req_q;
    d_req_d   = d_req_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    hold_d    = SEL_NONE;
    if (io_slv_hready) begin
      owner_d = addr_sel;
      if (addr_sel != SEL_NONE) rr_last_d = addr_sel;
      if (addr_sel == SEL_I) i_pend_d = 1'b0;
      if (addr_sel == SEL_D) d_pend_d = 1'b0;
    end else begin
      hold_d = addr_sel;
    end
    if (i_cap) begin
      i_pend_d = 1'b1;
      i_req_d  = '{addr: io_imem_haddr, write: io_imem_hwrite, size: io_imem_hsize,
                   prot: io_imem_hprot, lock: io_imem_hmastlock};
    end
    if (d_cap) begin
      d_pend_d = 1'b1;
      d_req_d  = '{addr: io_dmem_haddr, write: io_dmem_hwrite, size: io_dmem_hsize,
                   prot: io_dmem_hprot, lock: io_dmem_hmastlock};
    end
  end

  always_comb begin
    io_slv_htrans    = 2'b00;
    io_slv_haddr     = '0;
    io_slv_hwrite    = 1'b0;
    io_slv_hsize     = '0;
    io_slv_hprot     = '0;
    io_slv_hmastlock = 1'b0;
    io_slv_hburst    = 3'b000;
    case (addr_sel)
      SEL_I: begin
        io_slv_htrans    = 2'b10;
        io_slv_haddr     = i_req_q.addr;
        io_slv_hwrite    = i_req_q.write;
        io_slv_hsize     = i_req_q.size;
        io_slv_hprot     = i_req_q.prot;
        io_slv_hmastlock = i_req_q.lock;
      end
      SEL_D: begin
        io_slv_htrans    = 2'b10;
        io_slv_haddr     = d_req_q.addr;
        io_slv_hwrite    = d_req_q.write;
        io_slv_hsize     = d_req_q.size;
        io_slv_hprot     = d_req_q.prot;
        io_slv_hmastlock = d_req_q.lock;
      end
      default: ;
    endcase

    io_slv_hwdata = '0;
    if (owner_q == SEL_I) io_slv_hwdata = io_imem_hwdata;
    if (owner_q == SEL_D) io_slv_hwdata = io_dmem_hwdata;

    imem_rdy       = i_pend_q ? 1'b0 : ((owner_q == SEL_I) ? io_slv_hready : 1'b1);
    dmem_rdy       = d_pend_q ? 1'b0 : ((owner_q == SEL_D) ? io_slv_hready : 1'b1);
    io_imem_hready = imem_rdy;
    io_dmem_hready = dmem_rdy;
    io_imem_hresp  = (owner_q == SEL_I) ? io_slv_hresp : 1'b0;
    io_dmem_hresp  = (owner_q == SEL_D) ? io_slv_hresp : 1'b0;
    io_imem_hrdata = io_slv_hrdata;
    io_dmem_hrdata = io_slv_hrdata;
  end

endmodule
